// File: rtl/ps2_key_display_ctrl_if.sv
// Bus between the PS/2 frame receiver, the key-event consumer and the seven-segment display.
// master drives the received bytes; slave is the display controller.
interface ps2_key_display_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       err_seen;
  logic [3:0] an;
  logic [6:0] ca;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  key_valid, key_code, key_break, key_ext, err_seen, an, ca
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output key_valid, key_code, key_break, key_ext, err_seen, an, ca
  );
endinterface

// File: rtl/ps2_key_display_ctrl.sv
// PS/2 scan-code prefix tracker and key-event generator, with a 4-digit history
// of make codes multiplexed onto an active-low seven-segment display.
//   state   | meaning
//   IDLE    | no prefix pending
//   E0      | extended prefix seen, waiting for the code
//   F0      | break prefix seen, waiting for the code
//   E0F0    | extended break prefix seen, waiting for the code
module ps2_key_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                   clk,
  input logic                   rst_n,
  ps2_key_display_ctrl_if.slave bus
);

  localparam int RF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            accept, expired;
  logic            emit, emit_brk, emit_ext;
  logic [RF_W-1:0] ref_cnt;
  logic [1:0]      sel;
  logic [6:0]      hist [4];

  function automatic logic [6:0] seg_decode(input logic [7:0] code, input logic ext);
    logic [6:0] seg;
    seg = DASH;
    if (!ext) begin
      case (code)
        8'h45:   seg = 7'b1000000;
        8'h16:   seg = 7'b1111001;
        8'h1E:   seg = 7'b0100100;
        8'h26:   seg = 7'b0110000;
        8'h25:   seg = 7'b0011001;
        8'h2E:   seg = 7'b0010010;
        8'h36:   seg = 7'b0000010;
        8'h3D:   seg = 7'b1111000;
        8'h3E:   seg = 7'b0000000;
        8'h46:   seg = 7'b0010000;
        8'h1C:   seg = 7'b0001000;
        8'h1B:   seg = 7'b0010010;
        8'h44:   seg = 7'b1000000;
        8'h2B:   seg = 7'b0001110;
        default: seg = DASH;
      endcase
    end
    return seg;
  endfunction

  assign accept  = bus.rx_valid & ~bus.rx_err;
  assign expired = (state != ST_IDLE) && (to_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A byte arriving in the expiry cycle is still decoded against the pending prefix.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    if (bus.rx_err) begin
      state_nxt = ST_IDLE;
    end else if (bus.rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (bus.rx_data == SC_E0)      state_nxt = ST_E0;
          else if (bus.rx_data == SC_F0) state_nxt = ST_F0;
          else                           emit = 1'b1;
        end
        ST_E0: begin
          if (bus.rx_data == SC_F0)      state_nxt = ST_E0F0;
          else if (bus.rx_data != SC_E0) begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_F0: begin
          if (bus.rx_data == SC_E0)      state_nxt = ST_E0;
          else if (bus.rx_data != SC_F0) begin
            emit      = 1'b1;
            emit_brk  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if (bus.rx_data == SC_E0)      state_nxt = ST_E0;
          else if (bus.rx_data != SC_F0) begin
            emit      = 1'b1;
            emit_brk  = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (expired) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                  to_cnt <= '0;
    else if (accept)                             to_cnt <= TO_LOAD;
    else if (bus.rx_err)                         to_cnt <= '0;
    else if (state != ST_IDLE && to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.key_valid <= 1'b0;
      bus.key_code  <= '0;
      bus.key_break <= 1'b0;
      bus.key_ext   <= 1'b0;
      bus.err_seen  <= 1'b0;
    end else begin
      bus.key_valid <= emit;
      bus.err_seen  <= bus.err_seen | bus.rx_err;
      if (emit) begin
        bus.key_code  <= bus.rx_data;
        bus.key_break <= emit_brk;
        bus.key_ext   <= emit_ext;
      end
    end
  end

  // Only make events feed the history; releases leave the display untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= BLANK;
    end else if (emit && !emit_brk) begin
      hist[3] <= hist[2];
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= seg_decode(bus.rx_data, emit_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
      bus.an  <= 4'b1111;
      bus.ca  <= BLANK;
    end else begin
      if (ref_cnt == RF_LAST) begin
        ref_cnt <= '0;
        sel     <= sel + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      bus.an <= ~(4'b0001 << sel);
      bus.ca <= hist[sel];
    end
  end

endmodule
